// File: rtl/result_writeback.sv
// rtl/result_writeback.sv - serialises finished output tiles into the output buffer and flags completion
module result_writeback #(
  parameter int WIDTH      = 32,
  parameter int ROW1       = 2,
  parameter int COL2       = 5,
  parameter int ROW_PE     = 4,
  parameter int COL_PE     = 4,
  parameter int HEIGHT_OUT = 256,
  localparam int AW        = $clog2(HEIGHT_OUT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            tile_valid,
  output logic                            tile_ready,
  input  logic [7:0]                      tile_i,
  input  logic [7:0]                      tile_j,
  input  logic [ROW_PE*COL_PE*WIDTH-1:0]  tile_data,
  input  logic                            wr_ready,
  output logic                            wr_en,
  output logic [AW-1:0]                   wr_addr,
  output logic [WIDTH-1:0]                wr_data,
  output logic                            done,
  output logic                            err
);

  localparam int N  = ROW_PE * COL_PE;
  localparam int EW = (N > 1) ? $clog2(N) : 1;
  localparam int NT = ROW1 * COL2;
  localparam int CW = $clog2(NT + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, FINISH} state_t;

  state_t              state, state_n;
  logic [N*WIDTH-1:0]  tile_q;
  logic [7:0]          ti_q, tj_q;
  logic [15:0]         idx_in, idx_q;
  logic [EW-1:0]       elem;
  logic [NT-1:0]       bitmap, bitmap_sh;
  logic [CW-1:0]       count;
  logic                err_q;
  logic                hs, fire, last, legal;
  logic [15:0]         e16, row16, col16;

  assign hs        = tile_valid && tile_ready;
  assign fire      = wr_en && wr_ready;
  assign last      = fire && (elem == EW'(N - 1));
  assign idx_in    = 16'(tile_i) * 16'(COL2) + 16'(tile_j);
  assign bitmap_sh = bitmap >> idx_in;
  // Out-of-range tiles never reach the bitmap lookup result because the range terms gate it.
  assign legal     = (tile_i < 8'(ROW1)) && (tile_j < 8'(COL2)) && !bitmap_sh[0];

  assign e16   = 16'(elem);
  assign row16 = 16'(ti_q) * 16'(ROW_PE) + e16 / 16'(COL_PE);
  assign col16 = 16'(tj_q) * 16'(COL_PE) + e16 % 16'(COL_PE);

  assign wr_addr = wr_en ? AW'(row16 * 16'(COL2 * COL_PE) + col16) : '0;
  assign wr_data = wr_en ? tile_q[elem*WIDTH +: WIDTH] : '0;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    tile_ready = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = COLLECT;
      end
      COLLECT: begin
        tile_ready = 1'b1;
        if (start)             state_n = COLLECT;
        else if (hs && legal)  state_n = DRAIN;
      end
      DRAIN: begin
        wr_en = 1'b1;
        if (start)     state_n = COLLECT;
        else if (last) state_n = (count == CW'(NT - 1)) ? FINISH : COLLECT;
      end
      FINISH: begin
        done = 1'b1;
        if (start) state_n = COLLECT;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_q <= '0;
      ti_q   <= '0;
      tj_q   <= '0;
      idx_q  <= '0;
      elem   <= '0;
      bitmap <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else if (start) begin
      elem   <= '0;
      bitmap <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == COLLECT && hs) begin
        if (legal) begin
          tile_q <= tile_data;
          ti_q   <= tile_i;
          tj_q   <= tile_j;
          idx_q  <= idx_in;
          elem   <= '0;
        end else begin
          err_q  <= 1'b1;
        end
      end
      if (state == DRAIN && fire) begin
        if (last) begin
          elem   <= '0;
          bitmap <= bitmap | (NT'(1) << idx_q);
          count  <= count + 1'b1;
        end else begin
          elem   <= elem + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_writeback.sv
// tb/tb_result_writeback.sv - directed self-checking bench for result_writeback
module tb_result_writeback;

  logic         clk = 1'b0;
  logic         rst, start, tile_valid, wr_ready;
  logic [7:0]   tile_i, tile_j;
  logic [511:0] tile_data;
  logic         tile_ready, wr_en, done, err;
  logic [7:0]   wr_addr;
  logic [31:0]  wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  int          cap_addr [16];
  logic [31:0] cap_data [16];
  int          cap_n, cap_cyc;
  logic        log_en   [40];
  int          log_addr [40];
  logic [31:0] log_data [40];
  logic        log_rdy  [40];
  int          bp_at = -1;
  int          bp_left = 0;
  logic        ok;
  int          exp_tab [16] = '{0, 1, 2, 3, 20, 21, 22, 23, 40, 41, 42, 43, 60, 61, 62, 63};

  always #5 clk = ~clk;

  result_writeback dut (
    .clk(clk), .rst(rst), .start(start), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_i(tile_i), .tile_j(tile_j), .tile_data(tile_data), .wr_ready(wr_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .err(err)
  );

  function automatic int exp_addr(input int i, input int j, input int e);
    return (i * 4 + e / 4) * 20 + j * 4 + e % 4;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic present(input int i, input int j, input int base, output logic acc);
    tile_i = i[7:0];
    tile_j = j[7:0];
    for (int e = 0; e < 16; e++) tile_data[e*32 +: 32] = 32'(base + e + 1);
    tile_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (tile_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (acc) @(negedge clk);
    tile_valid = 1'b0;
  endtask

  task automatic capture();
    cap_n = 0;
    cap_cyc = 0;
    while (cap_n < 16 && cap_cyc < 40) begin
      wr_ready = !(cap_n == bp_at && bp_left > 0);
      if (!wr_ready) bp_left--;
      log_en[cap_cyc]   = wr_en;
      log_addr[cap_cyc] = int'(wr_addr);
      log_data[cap_cyc] = wr_data;
      log_rdy[cap_cyc]  = wr_ready;
      if (wr_en && wr_ready) begin
        cap_addr[cap_n] = int'(wr_addr);
        cap_data[cap_n] = wr_data;
        cap_n++;
      end
      cap_cyc++;
      @(negedge clk);
    end
    wr_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tile_valid = 1'b0; wr_ready = 1'b1;
    tile_i = '0; tile_j = '0; tile_data = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (tile_ready !== 1'b0) begin n_bad++; $display("FAIL reset_tile_ready got %b exp 0", tile_ready); end
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    n_cmp++; if (wr_addr !== 8'd0) begin n_bad++; $display("FAIL reset_wr_addr got %0d exp 0", wr_addr); end
    n_cmp++; if (wr_data !== 32'd0) begin n_bad++; $display("FAIL reset_wr_data got %0d exp 0", wr_data); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", err); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (tile_ready !== 1'b0) begin n_bad++; $display("FAIL idle_tile_ready got %b exp 0", tile_ready); end
  endtask

  task automatic test_single();
    pulse_start();
    present(0, 0, 0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_handshake got %b exp 1", ok); end
    capture();
    n_cmp++; if (log_en[0] !== 1'b1) begin n_bad++; $display("FAIL single_first_wr_en got %b exp 1", log_en[0]); end
    n_cmp++; if (cap_cyc !== 16) begin n_bad++; $display("FAIL single_cycles got %0d exp 16", cap_cyc); end
    for (int e = 0; e < 16; e++) begin
      n_cmp++;
      if (cap_addr[e] !== exp_tab[e] || cap_data[e] !== 32'(e + 1)) begin
        n_bad++;
        $display("FAIL single_elem%0d got addr %0d data %0d exp addr %0d data %0d", e, cap_addr[e], cap_data[e], exp_tab[e], e + 1);
      end
    end
    n_cmp++; if (tile_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_after got %b exp 1", tile_ready); end
  endtask

  task automatic test_full_pass();
    int i, j;
    pulse_start();
    for (int n = 0; n < 10; n++) begin
      i = (n == 0) ? 1 : (n - 1) / 5;
      j = (n == 0) ? 4 : (n - 1) % 5;
      present(i, j, n * 16, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL full_handshake tile (%0d,%0d) got %b exp 1", i, j, ok); end
      capture();
      n_cmp++; if (cap_n !== 16) begin n_bad++; $display("FAIL full_count tile (%0d,%0d) got %0d exp 16", i, j, cap_n); end
      for (int e = 0; e < 16; e++) begin
        n_cmp++;
        if (cap_addr[e] !== exp_addr(i, j, e) || cap_data[e] !== 32'(n * 16 + e + 1)) begin
          n_bad++;
          $display("FAIL full_elem (%0d,%0d) e%0d got addr %0d data %0d exp addr %0d data %0d", i, j, e, cap_addr[e], cap_data[e], exp_addr(i, j, e), n * 16 + e + 1);
        end
      end
      if (n == 0) begin
        n_cmp++; if (cap_addr[0] !== 96 || cap_addr[15] !== 159) begin n_bad++; $display("FAIL full_tile14_span got %0d..%0d exp 96..159", cap_addr[0], cap_addr[15]); end
      end
      if (n == 8) begin
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL full_done_early got %b exp 0", done); end
      end
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL full_done got %b exp 1", done); end
    tile_i = 8'd0; tile_j = 8'd0; tile_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b1 || tile_ready !== 1'b0 || wr_en !== 1'b0) begin
        n_bad++;
        $display("FAIL finish_hold cyc %0d got done %b ready %b wr_en %b exp 1 0 0", k, done, tile_ready, wr_en);
      end
    end
    tile_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int stalls;
    pulse_start();
    present(0, 1, 100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_handshake got %b exp 1", ok); end
    bp_at = 4; bp_left = 3;
    capture();
    bp_at = -1;
    n_cmp++; if (cap_cyc !== 19) begin n_bad++; $display("FAIL bp_cycles got %0d exp 19", cap_cyc); end
    n_cmp++; if (cap_n !== 16) begin n_bad++; $display("FAIL bp_count got %0d exp 16", cap_n); end
    for (int e = 0; e < 16; e++) begin
      n_cmp++;
      if (cap_addr[e] !== exp_addr(0, 1, e) || cap_data[e] !== 32'(101 + e)) begin
        n_bad++;
        $display("FAIL bp_elem%0d got addr %0d data %0d exp addr %0d data %0d", e, cap_addr[e], cap_data[e], exp_addr(0, 1, e), 101 + e);
      end
    end
    stalls = 0;
    for (int c = 0; c < cap_cyc; c++) begin
      if (!log_rdy[c]) begin
        stalls++;
        n_cmp++;
        if (log_en[c] !== 1'b1 || log_addr[c] !== 24 || log_data[c] !== 32'd105) begin
          n_bad++;
          $display("FAIL bp_hold cyc %0d got en %b addr %0d data %0d exp 1 24 105", c, log_en[c], log_addr[c], log_data[c]);
        end
      end
    end
    n_cmp++; if (stalls !== 3) begin n_bad++; $display("FAIL bp_stalls got %0d exp 3", stalls); end
  endtask

  task automatic test_dup();
    pulse_start();
    present(0, 2, 200, ok);
    capture();
    n_cmp++; if (cap_n !== 16 || cap_addr[0] !== 8) begin n_bad++; $display("FAIL dup_first got n %0d addr %0d exp 16 8", cap_n, cap_addr[0]); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL dup_err_before got %b exp 0", err); end
    present(0, 2, 300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL dup_accept got %b exp 1", ok); end
    n_cmp++;
    if (wr_en !== 1'b0 || err !== 1'b1 || tile_ready !== 1'b1) begin
      n_bad++; $display("FAIL dup_drop got wr_en %b err %b ready %b exp 0 1 1", wr_en, err, tile_ready);
    end
    present(2, 0, 400, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL illegal_accept got %b exp 1", ok); end
    n_cmp++;
    if (wr_en !== 1'b0 || err !== 1'b1) begin
      n_bad++; $display("FAIL illegal_drop got wr_en %b err %b exp 0 1", wr_en, err);
    end
    for (int n = 0; n < 10; n++) begin
      if (n == 2 || n == 6) continue;
      present(n / 5, n % 5, 1000 + n * 16, ok);
      capture();
      n_cmp++;
      if (ok !== 1'b1 || cap_n !== 16) begin
        n_bad++; $display("FAIL dup_fill tile %0d got acc %b n %0d exp 1 16", n, ok, cap_n);
      end
    end
    n_cmp++; if (done !== 1'b0 || err !== 1'b1) begin n_bad++; $display("FAIL dup_after got done %b err %b exp 0 1", done, err); end
  endtask

  task automatic test_restart();
    present(1, 1, 500, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL restart_accept got %b exp 1", ok); end
    repeat (7) @(negedge clk);
    n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 8'd107) begin n_bad++; $display("FAIL restart_elem7 got en %b addr %0d exp 1 107", wr_en, wr_addr); end
    pulse_start();
    n_cmp++;
    if (wr_en !== 1'b0 || done !== 1'b0 || err !== 1'b0 || tile_ready !== 1'b1) begin
      n_bad++; $display("FAIL restart_clear got wr_en %b done %b err %b ready %b exp 0 0 0 1", wr_en, done, err, tile_ready);
    end
    present(1, 1, 600, ok);
    n_cmp++; if (ok !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 8'd84) begin n_bad++; $display("FAIL restart_new got acc %b en %b addr %0d exp 1 1 84", ok, wr_en, wr_addr); end
    capture();
    n_cmp++; if (cap_n !== 16 || cap_data[15] !== 32'd616 || cap_addr[15] !== 147) begin n_bad++; $display("FAIL restart_drain got n %0d data %0d addr %0d exp 16 616 147", cap_n, cap_data[15], cap_addr[15]); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL restart_done got %b exp 0", done); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    present(0, 3, 700, ok);
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 8'd15) begin n_bad++; $display("FAIL rstmid_elem3 got en %b addr %0d exp 1 15", wr_en, wr_addr); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (tile_ready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 8'd0 || wr_data !== 32'd0 || done !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_outputs got ready %b en %b addr %0d data %0d done %b err %b exp all 0", tile_ready, wr_en, wr_addr, wr_data, done, err);
    end
    tile_i = 8'd0; tile_j = 8'd0; tile_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (tile_ready !== 1'b0 || wr_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_ignore cyc %0d got ready %b en %b exp 0 0", k, tile_ready, wr_en); end
    end
    tile_valid = 1'b0;
    pulse_start();
    present(0, 3, 800, ok);
    n_cmp++; if (ok !== 1'b1 || wr_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_resume got acc %b en %b exp 1 1", ok, wr_en); end
    capture();
    n_cmp++; if (cap_n !== 16 || cap_addr[0] !== 12 || cap_data[0] !== 32'd801) begin n_bad++; $display("FAIL rstmid_drain got n %0d addr %0d data %0d exp 16 12 801", cap_n, cap_addr[0], cap_data[0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_pass();
    test_backpressure();
    test_dup();
    test_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
